// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC ownership, single-outstanding imem handshake, IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN: traps misaligned redirect targets instead of fetching them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        JumpFlag,
  input  logic [31:0] JumpAddr,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic        IfIdValid,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPCPlus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        IfIdMisalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] plus4_q, plus4_d;
  logic        load;
  logic [31:0] load_instr;
  logic        accept;
  logic        park_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        park_d;
  logic        mis_q, mis_d;
  logic        target_misaligned;

  assign target_misaligned = (JumpAddr[1:0] != 2'b00);
  assign IfIdMisalign      = mis_q;
`else
  assign park_q = 1'b0;
`endif

  // A parked fetcher (after a misaligned redirect) keeps ImemReq low while sitting in REQ.
  assign ImemReq  = !rst && (state_q == REQ) && !park_q;
  assign ImemAddr = pc_q;
  assign accept   = ImemReq && ImemReady;

  assign IfIdValid   = valid_q;
  assign IfIdPC      = if_pc_q;
  assign IfIdInstr   = instr_q;
  assign IfIdPCPlus4 = plus4_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    skid_d     = skid_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    instr_d    = instr_q;
    plus4_d    = plus4_q;
    load       = 1'b0;
    load_instr = NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
    park_d     = park_q;
    mis_d      = mis_q;
`endif

    if (JumpFlag) begin
      // Redirect beats Stall and any response; an in-flight request is marked for discard.
      pc_d    = JumpAddr;
      valid_d = 1'b0;
      state_d = REQ;
      case (state_q)
        WAIT: begin
          if (!ImemRspValid) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end else begin
            drop_d = 1'b0;
          end
        end
        REQ: begin
          if (accept) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: ;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      park_d = target_misaligned;
      mis_d  = target_misaligned;
      if (target_misaligned) begin
        valid_d = 1'b1;
        if_pc_d = JumpAddr;
        instr_d = NOP;
        plus4_d = JumpAddr + 32'd4;
      end
`endif
    end else begin
      case (state_q)
        REQ: begin
          if (accept) state_d = WAIT;
        end
        WAIT: begin
          if (ImemRspValid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (!Stall) begin
              load       = 1'b1;
              load_instr = ImemRspData;
            end else begin
              skid_d  = ImemRspData;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            load       = 1'b1;
            load_instr = skid_q;
          end
        end
        default: state_d = REQ;
      endcase

      // Stall freezes IF/ID; otherwise an unloaded cycle becomes a bubble.
      if (load) begin
        valid_d = 1'b1;
        if_pc_d = pc_q;
        instr_d = load_instr;
        plus4_d = pc_q + 32'd4;
        pc_d    = pc_q + 32'd4;
        state_d = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
      end else if (!Stall) begin
        valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      skid_q  <= NOP;
      valid_q <= 1'b0;
      if_pc_q <= 32'h0;
      instr_q <= NOP;
      plus4_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
      plus4_q <= plus4_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      park_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      park_q <= park_d;
      mis_q  <= mis_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0x100); covers FETCH_MISALIGN_CHECK_EN when defined.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        JumpFlag;
  logic [31:0] JumpAddr;
  logic        Stall;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        IfIdValid;
  logic [31:0] IfIdPC;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPCPlus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        IfIdMisalign;
`endif

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .JumpFlag     (JumpFlag),
    .JumpAddr     (JumpAddr),
    .Stall        (Stall),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemReady    (ImemReady),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .IfIdValid    (IfIdValid),
    .IfIdPC       (IfIdPC),
    .IfIdInstr    (IfIdInstr),
    .IfIdPCPlus4  (IfIdPCPlus4)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .IfIdMisalign (IfIdMisalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic jf, input logic [31:0] ja, input logic st,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    JumpFlag     = jf;
    JumpAddr     = ja;
    Stall        = st;
    ImemReady    = rdy;
    ImemRspValid = rv;
    ImemRspData  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_valid", {31'b0, IfIdValid}, 0);
    checkOutput("rst_pc", IfIdPC, 0);
    checkOutput("rst_instr", IfIdInstr, NOP);
    checkOutput("rst_plus4", IfIdPCPlus4, 0);
    checkOutput("rst_req", {31'b0, ImemReq}, 0);
    rst = 1'b0;
    #1;
    checkOutput("first_req", {31'b0, ImemReq}, 1);
    checkOutput("first_addr", ImemAddr, 32'h100);

    // Zero-wait fetch of 0x100.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait_req", {31'b0, ImemReq}, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h00A00093);
    checkOutput("f1_valid", {31'b0, IfIdValid}, 1);
    checkOutput("f1_pc", IfIdPC, 32'h100);
    checkOutput("f1_instr", IfIdInstr, 32'h00A00093);
    checkOutput("f1_plus4", IfIdPCPlus4, 32'h104);
    checkOutput("f1_next_addr", ImemAddr, 32'h104);
    checkOutput("f1_next_req", {31'b0, ImemReq}, 1);

    // Response arrives under a 3-cycle stall.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bubble_valid", {31'b0, IfIdValid}, 0);
    applyStimulus(0, 0, 1, 0, 1, 32'h00100113);
    checkOutput("stall1_valid", {31'b0, IfIdValid}, 0);
    checkOutput("stall1_pc", IfIdPC, 32'h100);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("stall2_pc", IfIdPC, 32'h100);
    checkOutput("stall2_req", {31'b0, ImemReq}, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("stall3_instr", IfIdInstr, 32'h00A00093);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("skid_valid", {31'b0, IfIdValid}, 1);
    checkOutput("skid_pc", IfIdPC, 32'h104);
    checkOutput("skid_instr", IfIdInstr, 32'h00100113);
    checkOutput("skid_plus4", IfIdPCPlus4, 32'h108);
    checkOutput("skid_next_addr", ImemAddr, 32'h108);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("skid_no_dup", {31'b0, IfIdValid}, 0);

    // Redirect to 0x200 while waiting; the late old response is dropped.
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h200, 0, 0, 0, 0);
    checkOutput("rdw_valid", {31'b0, IfIdValid}, 0);
    checkOutput("rdw_req", {31'b0, ImemReq}, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("rdw_drop_valid", {31'b0, IfIdValid}, 0);
    checkOutput("rdw_req2", {31'b0, ImemReq}, 1);
    checkOutput("rdw_addr", ImemAddr, 32'h200);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0297);
    checkOutput("rdw_f_valid", {31'b0, IfIdValid}, 1);
    checkOutput("rdw_f_pc", IfIdPC, 32'h200);
    checkOutput("rdw_f_instr", IfIdInstr, 32'h0000_0297);

    // Redirect, response and stall together: redirect wins.
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h400, 1, 0, 1, 32'h1111_1111);
    checkOutput("jrs_valid", {31'b0, IfIdValid}, 0);
    checkOutput("jrs_req", {31'b0, ImemReq}, 1);
    checkOutput("jrs_addr", ImemAddr, 32'h400);

    // Redirect in REQ without ready switches the address; wraparound fetch.
    applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    checkOutput("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, NOP);
    checkOutput("wrap_pc", IfIdPC, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", IfIdPCPlus4, 0);
    checkOutput("wrap_next_addr", ImemAddr, 0);

    // Redirect with ready: old-address request accepted, its response dropped.
    applyStimulus(1, 32'h500, 0, 1, 0, 0);
    checkOutput("rdr_req", {31'b0, ImemReq}, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h2222_2222);
    checkOutput("rdr_valid", {31'b0, IfIdValid}, 0);
    checkOutput("rdr_addr", ImemAddr, 32'h500);
    checkOutput("rdr_req2", {31'b0, ImemReq}, 1);

`ifdef FETCH_MISALIGN_CHECK_EN
    applyStimulus(1, 32'h202, 0, 0, 0, 0);
    checkOutput("mis_valid", {31'b0, IfIdValid}, 1);
    checkOutput("mis_flag", {31'b0, IfIdMisalign}, 1);
    checkOutput("mis_pc", IfIdPC, 32'h202);
    checkOutput("mis_instr", IfIdInstr, NOP);
    checkOutput("mis_req", {31'b0, ImemReq}, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("mis_park_req", {31'b0, ImemReq}, 0);
    applyStimulus(1, 32'h300, 0, 0, 0, 0);
    checkOutput("mis_exit_req", {31'b0, ImemReq}, 1);
    checkOutput("mis_exit_addr", ImemAddr, 32'h300);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0033);
    checkOutput("mis_norm_valid", {31'b0, IfIdValid}, 1);
    checkOutput("mis_norm_flag", {31'b0, IfIdMisalign}, 0);
    checkOutput("mis_norm_pc", IfIdPC, 32'h300);
`else
    applyStimulus(1, 32'h202, 0, 0, 0, 0);
    checkOutput("mis_pass_req", {31'b0, ImemReq}, 1);
    checkOutput("mis_pass_addr", ImemAddr, 32'h202);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0033);
    checkOutput("mis_pass_pc", IfIdPC, 32'h202);
    checkOutput("mis_pass_plus4", IfIdPCPlus4, 32'h206);
`endif

    // Reset mid-transaction; a late response right after reset is ignored.
    applyStimulus(0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mrst_req", {31'b0, ImemReq}, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 32'h3333_3333);
    checkOutput("mrst_valid", {31'b0, IfIdValid}, 0);
    checkOutput("mrst_req2", {31'b0, ImemReq}, 1);
    checkOutput("mrst_addr", ImemAddr, 32'h100);
    checkOutput("mrst_instr", IfIdInstr, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
